// File: rtl/ssd_scan_reader.sv
// ssd_scan_reader: watches two multiplexed 2-digit seven-segment buses
// and recovers the four displayed digits as BCD, with per-digit valid,
// a frame strobe and a sticky undecodable-pattern flag.
// A (seg_en, segments) sample must stay unchanged for SETTLE cycles before
// it is captured, so short glitches and scan transitions are ignored.
// SETTLE must be at least 2.
module ssd_scan_reader #(
  parameter int SETTLE     = 16,
  parameter int TIMEOUT    = 65536,
  parameter bit SEG_ACT_LO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] seg_en,
  input  logic [6:0] seg_ab,
  input  logic [6:0] seg_cd,
  output logic [3:0] digit_a,
  output logic [3:0] digit_b,
  output logic [3:0] digit_c,
  output logic [3:0] digit_d,
  output logic [3:0] valid,
  output logic       frame,
  output logic       err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Entering CAPTURE coincides with the settle counter reaching SETTLE-1.
  localparam logic [SW-1:0] SETTLE_PRE = SW'(SETTLE - 2);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {TRACK, CAPTURE, HOLD} lane_state_t;

  // Returns {ok, bcd}; blank (all segments off) decodes to 4'hF.
  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'h3F:   dec7 = {1'b1, 4'd0};
      7'h06:   dec7 = {1'b1, 4'd1};
      7'h5B:   dec7 = {1'b1, 4'd2};
      7'h4F:   dec7 = {1'b1, 4'd3};
      7'h66:   dec7 = {1'b1, 4'd4};
      7'h6D:   dec7 = {1'b1, 4'd5};
      7'h7D:   dec7 = {1'b1, 4'd6};
      7'h07:   dec7 = {1'b1, 4'd7};
      7'h7F:   dec7 = {1'b1, 4'd8};
      7'h6F:   dec7 = {1'b1, 4'd9};
      7'h00:   dec7 = {1'b1, 4'hF};
      default: dec7 = {1'b0, 4'h0};
    endcase
  endfunction

  logic [1:0] en_p0, en_p1;
  logic [6:0] ab_p0, ab_p1;
  logic [6:0] cd_p0, cd_p1;

  // Stage p0/p1: two-flop synchronizer on every pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_p0 <= '0;
      en_p1 <= '0;
      ab_p0 <= '0;
      ab_p1 <= '0;
      cd_p0 <= '0;
      cd_p1 <= '0;
    end else begin
      en_p0 <= seg_en;
      en_p1 <= en_p0;
      ab_p0 <= seg_ab;
      ab_p1 <= ab_p0;
      cd_p0 <= seg_cd;
      cd_p1 <= cd_p0;
    end
  end

  // Lane sample = {digit select, active-high segments}.
  logic [7:0] samp [2];

  // Polarity correction after the synchronizer, per lane.
  always_comb begin
    samp[0] = {en_p1[0], (SEG_ACT_LO ? ~ab_p1 : ab_p1)};
    samp[1] = {en_p1[1], (SEG_ACT_LO ? ~cd_p1 : cd_p1)};
  end

  lane_state_t   state_q [2];
  logic [7:0]    prev_q  [2];
  logic [SW-1:0] cnt_q   [2];

  // Lane FSM: any sample change restarts settling; a stable interval is captured once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= TRACK;
        prev_q[l]  <= '0;
        cnt_q[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        prev_q[l] <= samp[l];
        if (samp[l] != prev_q[l]) begin
          state_q[l] <= TRACK;
          cnt_q[l]   <= '0;
        end else begin
          case (state_q[l])
            TRACK: begin
              cnt_q[l] <= cnt_q[l] + 1'b1;
              if (cnt_q[l] == SETTLE_PRE) state_q[l] <= CAPTURE;
            end
            CAPTURE: state_q[l] <= HOLD;
            HOLD:    state_q[l] <= HOLD;
            default: state_q[l] <= TRACK;
          endcase
        end
      end
    end
  end

  logic [1:0] cap;
  logic [1:0] ok;
  logic [3:0] dec_val [2];
  logic [3:0] wr;
  logic [3:0] wr_val  [4];

  // Decode the stable lane samples and steer each capture to its digit slot.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      cap[l]     = (state_q[l] == CAPTURE);
      ok[l]      = dec7(prev_q[l][6:0])[4];
      dec_val[l] = dec7(prev_q[l][6:0])[3:0];
    end
    wr[0]     = cap[0] & ok[0] &  prev_q[0][7];
    wr[1]     = cap[0] & ok[0] & ~prev_q[0][7];
    wr[2]     = cap[1] & ok[1] &  prev_q[1][7];
    wr[3]     = cap[1] & ok[1] & ~prev_q[1][7];
    wr_val[0] = dec_val[0];
    wr_val[1] = dec_val[0];
    wr_val[2] = dec_val[1];
    wr_val[3] = dec_val[1];
  end

  logic [3:0]    digit_q [4];
  logic [TW-1:0] to_q    [4];
  logic [3:0]    valid_q;
  logic [3:0]    fresh_q;
  logic          frame_q;
  logic          err_q;

  // Digit registers, staleness timeouts, frame tracking and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= '0;
        to_q[i]    <= '0;
      end
      valid_q <= '0;
      fresh_q <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) begin
          digit_q[i] <= wr_val[i];
          valid_q[i] <= 1'b1;
          to_q[i]    <= '0;
        end else if (to_q[i] != TO_MAX) begin
          to_q[i] <= to_q[i] + 1'b1;
          if (to_q[i] == TO_LAST) valid_q[i] <= 1'b0;
        end
      end
      if (|(cap & ~ok)) err_q <= 1'b1;
      if ((fresh_q | wr) == 4'hF) begin
        fresh_q <= '0;
        frame_q <= 1'b1;
      end else begin
        fresh_q <= fresh_q | wr;
        frame_q <= 1'b0;
      end
    end
  end

  assign digit_a = digit_q[0];
  assign digit_b = digit_q[1];
  assign digit_c = digit_q[2];
  assign digit_d = digit_q[3];
  assign valid   = valid_q;
  assign frame   = frame_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Directed bench for ssd_scan_reader: a default build, a short-timeout
// build and an active-low build, each driven by its own pins.
module tb_ssd_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] en,  en_t,  en_n;
  logic [6:0] ab,  ab_t,  ab_n;
  logic [6:0] cd,  cd_t,  cd_n;
  logic [3:0] da,  db,  dc,  dd,  vld;
  logic [3:0] da_t, db_t, dc_t, dd_t, vld_t;
  logic [3:0] da_n, db_n, dc_n, dd_n, vld_n;
  logic       frm, frm_t, frm_n;
  logic       er,  er_t,  er_n;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  ssd_scan_reader #(.SETTLE(16), .TIMEOUT(65536), .SEG_ACT_LO(1'b0)) dut (
    .clk(clk), .rst(rst), .seg_en(en), .seg_ab(ab), .seg_cd(cd),
    .digit_a(da), .digit_b(db), .digit_c(dc), .digit_d(dd),
    .valid(vld), .frame(frm), .err(er));

  ssd_scan_reader #(.SETTLE(16), .TIMEOUT(64), .SEG_ACT_LO(1'b0)) dut_t (
    .clk(clk), .rst(rst), .seg_en(en_t), .seg_ab(ab_t), .seg_cd(cd_t),
    .digit_a(da_t), .digit_b(db_t), .digit_c(dc_t), .digit_d(dd_t),
    .valid(vld_t), .frame(frm_t), .err(er_t));

  ssd_scan_reader #(.SETTLE(16), .TIMEOUT(65536), .SEG_ACT_LO(1'b1)) dut_n (
    .clk(clk), .rst(rst), .seg_en(en_n), .seg_ab(ab_n), .seg_cd(cd_n),
    .digit_a(da_n), .digit_b(db_n), .digit_c(dc_n), .digit_d(dd_n),
    .valid(vld_n), .frame(frm_n), .err(er_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge and counting frame pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      frames += int'(frm);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 2'b11; ab   = 7'h06; cd   = 7'h4F;
    en_t = 2'b00; ab_t = 7'h00; cd_t = 7'h00;
    en_n = 2'b00; ab_n = 7'h00; cd_n = 7'h00;

    // Reset held with live inputs
    step(3);
    chk("rst_digit_a", 32'(da), 32'h0);
    chk("rst_digit_b", 32'(db), 32'h0);
    chk("rst_digit_c", 32'(dc), 32'h0);
    chk("rst_digit_d", 32'(dd), 32'h0);
    chk("rst_valid",   32'(vld), 32'h0);
    chk("rst_err",     32'(er), 32'h0);
    chk("rst_frames",  32'(frames), 32'h0);

    // Basic scan: a=1 c=3 then b=2 d=4
    rst = 1'b0;
    frames = 0;
    step(40);
    en = 2'b00; ab = 7'h5B; cd = 7'h66;
    step(40);
    chk("scan_digit_a", 32'(da), 32'h1);
    chk("scan_digit_b", 32'(db), 32'h2);
    chk("scan_digit_c", 32'(dc), 32'h3);
    chk("scan_digit_d", 32'(dd), 32'h4);
    chk("scan_valid",   32'(vld), 32'hF);
    chk("scan_frames",  32'(frames), 32'h1);
    chk("scan_err",     32'(er), 32'h0);

    // Glitching AB segments shorter than the settle window
    for (int k = 0; k < 12; k++) begin
      ab = (k % 2 == 0) ? 7'h06 : 7'h5B;
      step(5);
    end
    chk("glitch_digit_b", 32'(db), 32'h2);
    chk("glitch_digit_a", 32'(da), 32'h1);
    chk("glitch_err",     32'(er), 32'h0);
    step(40);
    chk("glitch_settled_b", 32'(db), 32'h2);
    chk("glitch_frames",    32'(frames), 32'h1);

    // Undecodable pattern, then valid ones: err stays set
    en = 2'b01; ab = 7'h49;
    step(40);
    chk("bad_err",     32'(er), 32'h1);
    chk("bad_digit_a", 32'(da), 32'h1);
    chk("bad_valid",   32'(vld), 32'hF);
    ab = 7'h6D;
    step(40);
    chk("after_bad_digit_a", 32'(da), 32'h5);
    chk("after_bad_err",     32'(er), 32'h1);
    ab = 7'h00;
    step(40);
    chk("blank_digit_a", 32'(da), 32'hF);
    chk("blank_valid_a", 32'(vld[0]), 32'h1);
    chk("blank_err",     32'(er), 32'h1);

    // Reset in the middle of operation
    rst = 1'b1;
    step(2);
    chk("midrst_digit_a", 32'(da), 32'h0);
    chk("midrst_valid",   32'(vld), 32'h0);
    chk("midrst_err",     32'(er), 32'h0);
    rst = 1'b0;

    // Short-timeout build: refresh all four, then stop CD refresh
    for (int r = 0; r < 6; r++) begin
      en_t = 2'b11; ab_t = 7'h06; cd_t = 7'h4F;
      step(25);
      en_t = 2'b00; ab_t = 7'h5B; cd_t = 7'h66;
      step(25);
    end
    chk("to_refresh_valid", 32'(vld_t), 32'hF);
    chk("to_refresh_d",     32'(dd_t), 32'h4);
    cd_t = 7'h4F;
    for (int r = 0; r < 4; r++) begin
      en_t = 2'b11; ab_t = 7'h06;
      step(25);
      en_t = 2'b10; ab_t = 7'h5B;
      step(25);
    end
    chk("to_cd_valid",  32'(vld_t[3:2]), 32'h0);
    chk("to_ab_valid",  32'(vld_t[1:0]), 32'h3);
    chk("to_digit_c",   32'(dc_t), 32'h3);
    chk("to_digit_d",   32'(dd_t), 32'h4);
    chk("to_digit_a",   32'(da_t), 32'h1);

    // Active-low build
    en_n = 2'b01; ab_n = 7'h79; cd_n = 7'h19;
    step(40);
    chk("actlo_digit_a1", 32'(da_n), 32'h1);
    chk("actlo_digit_d",  32'(dd_n), 32'h4);
    ab_n = 7'h40;
    step(40);
    chk("actlo_digit_a0", 32'(da_n), 32'h0);
    chk("actlo_valid_a",  32'(vld_n[0]), 32'h1);
    chk("actlo_err",      32'(er_n), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
